hello_rot_decoder: RTL and testbench
====================================

HELLO_ROT_DECODER -- requirements
Module: hello_rot_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of HEX digits scanned; only 6 is supported.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; one clock, all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a decode; accepted only in IDLE.
REQ-005 SHALL have ports HEX5..HEX0  input  7 each  active-low segment patterns, bit0 = segment a, bit6 = segment g.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-008 SHALL have port rot  output  3  recovered rotation index 0..5; 7 = no match.
REQ-009 SHALL have port match  output  1  the six digits form a rotation of "blank H E L L O".
REQ-010 SHALL have port err  output  1  at least one pattern is not H/E/L/O/blank.

Function
REQ-011 SHALL capture HEX5..HEX0 into internal registers on the edge where start=1 in IDLE (call this edge T), and SHALL ignore later input changes until the next accepted start.
REQ-012 SHALL decode patterns as follows; any other pattern decodes to INV (7).
- 0001001 -> H (0)
- 0000110 -> E (1)
- 1000111 -> L (2)
- 1000000 -> O (3)
- 1111111 -> BLK (4)
REQ-013 SHALL use states IDLE -> SCAN -> MATCH -> DONE -> IDLE.
REQ-014 SCAN SHALL decode one digit per cycle, HEX5 first, HEX0 last, in cycles T+1..T+6.
REQ-015 MATCH SHALL test candidate s = 0..5, one per cycle, in cycles T+7..T+12.
- Candidate s matches when, for k = 0..5, digit HEX(5-k) = MSG[(s+k) mod 6].
- MSG = BLK,H,E,L,L,O.
REQ-016 SHALL report the lowest matching s in rot with match=1; with no match, rot=7 and match=0.
REQ-017 SHALL assert done for exactly one cycle, in cycle T+13, then return to IDLE.
REQ-018 SHALL hold rot/match/err stable from done until the next accepted start; on accepted start they SHALL clear to reset values.
REQ-019 SHALL set err=1 if any digit decodes INV; err=1 forces match=0 and rot=7.
REQ-020 SHALL ignore start while busy=1; no queuing.
REQ-021 start asserted in the DONE cycle SHALL be ignored; start is accepted the following cycle.

Reset
REQ-022 RESET=1 at any edge SHALL force IDLE and set busy=0, done=0, rot=7, match=0, err=0, and clear captured digits to BLK.
REQ-023 RESET mid-operation SHALL abort with no done pulse; RESET has priority over start.

Configuration
REQ-024 With macro HELLO_DEC_ABORT_EN defined, the first INV digit found in SCAN SHALL abort the operation.
- Remaining digits and MATCH are skipped.
- done is asserted in the cycle after detection, with err=1, match=0, rot=7.
REQ-025 Without HELLO_DEC_ABORT_EN, latency SHALL be fixed at 13 cycles regardless of err.

Structure
REQ-026 A shared package hello_pkg SHALL hold:
- the 3-bit char codes H/E/L/O/BLK/INV;
- the five segment constants;
- the MSG table;
- NUM_DIGITS;
- the state enum.
REQ-027 Pattern-to-code decoding SHALL be a combinational sub-module seg_char_decode (7-bit in, 3-bit out), instantiated once and fed by the digit under scan.

Verification
REQ-028 HEX5..0 = 1111111,0001001,0000110,1000111,1000111,1000000 with start at T -> done at T+13, rot=0, match=1, err=0.
REQ-029 HEX5..0 = 1000111,1000111,1000000,1111111,0001001,0000110 -> rot=3, match=1, err=0.
REQ-030 All six HEX = 1111111 -> rot=7, match=0, err=0, done at T+13.
REQ-031 HEX2 = 0000000, others as REQ-028 -> err=1, match=0, rot=7; done at T+13 without macro, at T+5 with HELLO_DEC_ABORT_EN.
REQ-032 RESET pulse at T+4 -> no done, busy=0 and rot=7 next cycle; a new start then completes normally in 13 cycles.
REQ-033 start re-pulsed at T+3 with different HEX values -> ignored; results reflect values captured at T.

Source files
------------

// File: rtl/hello_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hello_pkg
// Purpose : Shared definitions for the HELLO rotation decoder: 3-bit
//           character codes, active-low segment patterns, the reference
//           message, the digit count and the controller state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package hello_pkg;

  localparam int c_NUM_DIGITS = 6;

  // Character codes produced by the segment decoder
  localparam logic [2:0] c_CH_H   = 3'd0;
  localparam logic [2:0] c_CH_E   = 3'd1;
  localparam logic [2:0] c_CH_L   = 3'd2;
  localparam logic [2:0] c_CH_O   = 3'd3;
  localparam logic [2:0] c_CH_BLK = 3'd4;
  localparam logic [2:0] c_CH_INV = 3'd7;

  // Rotation value reported when nothing matches
  localparam logic [2:0] c_ROT_NONE = 3'd7;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] c_SEG_H   = 7'b0001001;
  localparam logic [6:0] c_SEG_E   = 7'b0000110;
  localparam logic [6:0] c_SEG_L   = 7'b1000111;
  localparam logic [6:0] c_SEG_O   = 7'b1000000;
  localparam logic [6:0] c_SEG_BLK = 7'b1111111;

  // Reference message "blank H E L L O"
  localparam logic [2:0] c_MSG [c_NUM_DIGITS] =
    '{c_CH_BLK, c_CH_H, c_CH_E, c_CH_L, c_CH_L, c_CH_O};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_MATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Message character at position (s + k) mod NUM_DIGITS; s, k in 0..5
  function automatic logic [2:0] msg_char(input logic [2:0] i_s,
                                          input logic [2:0] i_k);
    logic [3:0] w_pos;
    w_pos = {1'b0, i_s} + {1'b0, i_k};
    if (w_pos >= 4'(c_NUM_DIGITS)) begin
      w_pos = w_pos - 4'(c_NUM_DIGITS);
    end
    return c_MSG[w_pos[2:0]];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_char_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg_char_decode
// Purpose : Combinational map from an active-low 7-segment pattern to a
//           3-bit character code. Unknown patterns map to INV.
// Ports   : i_seg  [6:0] - segment pattern (bit0 = a, bit6 = g)
//           o_code [2:0] - character code (H/E/L/O/BLK/INV)
// Revision: 1.0 - initial release
// ============================================================================
module seg_char_decode
  import hello_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [2:0] o_code
);

  always_comb begin
    o_code = c_CH_INV;
    case (i_seg)
      c_SEG_H:   o_code = c_CH_H;
      c_SEG_E:   o_code = c_CH_E;
      c_SEG_L:   o_code = c_CH_L;
      c_SEG_O:   o_code = c_CH_O;
      c_SEG_BLK: o_code = c_CH_BLK;
      default:   o_code = c_CH_INV;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hello_rot_decoder.sv
`default_nettype none
// ============================================================================
// Module  : hello_rot_decoder
// Purpose : Captures six 7-segment digits on start, decodes them one per
//           cycle (HEX5 first), then tests the six rotations of
//           "blank H E L L O" one per cycle and reports the lowest match.
//           Without abort the result appears with done 13 cycles after the
//           accepting edge.
// Ports   : CLOCK_50        in  - clock, rising edge
//           RESET           in  - synchronous active-high reset
//           start           in  - decode request, accepted only in IDLE
//           HEX5..HEX0 [6:0]in  - active-low segment patterns
//           busy            out - high whenever not IDLE
//           done            out - one-cycle result strobe
//           rot        [2:0]out - rotation index 0..5, 7 = none
//           match           out - digits form a rotation of the message
//           err             out - at least one digit is not H/E/L/O/blank
// Config  : HELLO_DEC_ABORT_EN - when defined, the first invalid digit seen
//           during the scan ends the operation early with err=1.
// Revision: 1.0 - initial release
// ============================================================================
module hello_rot_decoder
  import hello_pkg::*;
#(
  parameter int NUM_DIGITS = c_NUM_DIGITS   // only 6 is supported
)(
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  input  logic [6:0] HEX5,
  input  logic [6:0] HEX4,
  input  logic [6:0] HEX3,
  input  logic [6:0] HEX2,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX0,
  output logic       busy,
  output logic       done,
  output logic [2:0] rot,
  output logic       match,
  output logic       err
);

  state_t     r_state;
  state_t     w_state_next;

  // Index 0 holds HEX5, index NUM_DIGITS-1 holds HEX0
  logic [6:0] r_hex  [NUM_DIGITS];
  logic [2:0] r_code [NUM_DIGITS];

  // Digit index while scanning, candidate rotation while matching
  logic [2:0] r_idx;
  logic       r_err_acc;
  logic       r_found;
  logic [2:0] r_best;

  logic [2:0] r_rot;
  logic       r_match;
  logic       r_err;

  logic [6:0] w_seg;
  logic [2:0] w_code;
  logic       w_inv;
  logic       w_last;
  logic       w_cand_ok;
  logic       w_busy;
  logic       w_done;

  assign w_seg  = r_hex[r_idx];
  assign w_inv  = (w_code == c_CH_INV);
  assign w_last = (r_idx == 3'(NUM_DIGITS - 1));

  seg_char_decode u_dec (
    .i_seg  (w_seg),
    .o_code (w_code)
  );

  // Candidate r_idx matches when every stored digit equals the rotated message
  always_comb begin
    w_cand_ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_code[k] != msg_char(r_idx, 3'(k))) begin
        w_cand_ok = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
`ifdef HELLO_DEC_ABORT_EN
        if (w_inv) begin
          w_state_next = ST_DONE;
        end else
`endif
        if (w_last) begin
          w_state_next = ST_MATCH;
        end
      end
      ST_MATCH: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // start is not looked at here; it is taken on the next IDLE cycle
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath ---
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_hex[i]  <= c_SEG_BLK;
        r_code[i] <= c_CH_BLK;
      end
      r_idx     <= 3'd0;
      r_err_acc <= 1'b0;
      r_found   <= 1'b0;
      r_best    <= c_ROT_NONE;
      r_rot     <= c_ROT_NONE;
      r_match   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_hex[0]  <= HEX5;
            r_hex[1]  <= HEX4;
            r_hex[2]  <= HEX3;
            r_hex[3]  <= HEX2;
            r_hex[4]  <= HEX1;
            r_hex[5]  <= HEX0;
            r_idx     <= 3'd0;
            r_err_acc <= 1'b0;
            r_found   <= 1'b0;
            r_best    <= c_ROT_NONE;
            r_rot     <= c_ROT_NONE;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        ST_SCAN: begin
          r_code[r_idx] <= w_code;
          if (w_inv) begin
            r_err_acc <= 1'b1;
          end
          r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
`ifdef HELLO_DEC_ABORT_EN
          if (w_inv) begin
            r_err   <= 1'b1;
            r_match <= 1'b0;
            r_rot   <= c_ROT_NONE;
          end
`endif
        end
        ST_MATCH: begin
          if (w_cand_ok && !r_found) begin
            r_found <= 1'b1;
            r_best  <= r_idx;
          end
          r_idx <= r_idx + 3'd1;
          // Publish on the last candidate; it may itself be the first hit
          if (w_last) begin
            if (r_err_acc) begin
              r_err   <= 1'b1;
              r_match <= 1'b0;
              r_rot   <= c_ROT_NONE;
            end else if (r_found) begin
              r_match <= 1'b1;
              r_rot   <= r_best;
            end else if (w_cand_ok) begin
              r_match <= 1'b1;
              r_rot   <= r_idx;
            end else begin
              r_match <= 1'b0;
              r_rot   <= c_ROT_NONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = w_busy;
  assign done  = w_done;
  assign rot   = r_rot;
  assign match = r_match;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hello_rot_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_hello_rot_decoder
// Purpose : Self-checking bench for hello_rot_decoder. Expected results are
//           queued when a start is driven and compared when done pulses.
// Config  : honours HELLO_DEC_ABORT_EN for the expected latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hello_rot_decoder;

  localparam logic [6:0] SH = 7'b0001001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SL = 7'b1000111;
  localparam logic [6:0] SO = 7'b1000000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b0000000;
  localparam logic [6:0] SY = 7'b0101010;

  typedef struct packed {
    logic [41:0] hex;     // HEX5 in [41:35] ... HEX0 in [6:0]
    logic [2:0]  rot;
    logic        match;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [2:0]  rot;
    logic        match;
    logic        err;
    logic [31:0] lat;
    logic [31:0] sc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] h5 = SB, h4 = SB, h3 = SB, h2 = SB, h1 = SB, h0 = SB;
  logic       busy, done, match, err;
  logic [2:0] rot;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned done_seen = 0;
  exp_t        sb [$];
  vec_t        vecs [11];

  hello_rot_decoder #(.NUM_DIGITS(6)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .start    (start),
    .HEX5     (h5),
    .HEX4     (h4),
    .HEX3     (h3),
    .HEX2     (h2),
    .HEX1     (h1),
    .HEX0     (h0),
    .busy     (busy),
    .done     (done),
    .rot      (rot),
    .match    (match),
    .err      (err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int first_inv(input logic [41:0] h);
    logic [6:0] d;
    for (int i = 0; i < 6; i++) begin
      d = h[41 - 7*i -: 7];
      if (!(d == SH || d == SE || d == SL || d == SO || d == SB)) return i;
    end
    return -1;
  endfunction

  function automatic int exp_lat(input logic [41:0] h);
`ifdef HELLO_DEC_ABORT_EN
    int j;
    j = first_inv(h);
    if (j >= 0) return j + 2;
`else
    if (first_inv(h) > 6) return 0;
`endif
    return 13;
  endfunction

  task automatic drive_hex(input logic [41:0] h);
    h5 = h[41:35]; h4 = h[34:28]; h3 = h[27:21];
    h2 = h[20:14]; h1 = h[13:7];  h0 = h[6:0];
  endtask

  task automatic push_exp(input vec_t v, input int unsigned sc);
    exp_t e;
    e.rot   = v.rot;
    e.match = v.match;
    e.err   = v.err;
    e.lat   = 32'(exp_lat(v.hex));
    e.sc    = sc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
    chk("completion_timeout_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("rot",     32'(rot),   32'(e.rot));
        chk("match",   32'(match), 32'(e.match));
        chk("err",     32'(err),   32'(e.err));
        chk("latency", cyc - e.sc, e.lat);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    drive_hex(v.hex);
    start = 1'b1;
    push_exp(v, cyc);
    @(negedge clk);                       // cycle T+1
    start = 1'b0;
    drive_hex({6{SX}});                   // must not affect captured digits
    chk({name, "_cleared"}, {busy, rot, match, err}, {1'b1, 3'd7, 1'b0, 1'b0});
    wait_idle();
    @(negedge clk);
    chk({name, "_hold"}, {busy, done, rot, match, err},
        {1'b0, 1'b0, v.rot, v.match, v.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{{SB, SH, SE, SL, SL, SO}, 3'd0, 1'b1, 1'b0};
    vecs[1]  = '{{SL, SL, SO, SB, SH, SE}, 3'd3, 1'b1, 1'b0};
    vecs[2]  = '{{SB, SB, SB, SB, SB, SB}, 3'd7, 1'b0, 1'b0};
    vecs[3]  = '{{SB, SH, SE, SX, SL, SO}, 3'd7, 1'b0, 1'b1};
    vecs[4]  = '{{SH, SE, SL, SL, SO, SB}, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{{SE, SL, SL, SO, SB, SH}, 3'd2, 1'b1, 1'b0};
    vecs[6]  = '{{SL, SO, SB, SH, SE, SL}, 3'd4, 1'b1, 1'b0};
    vecs[7]  = '{{SO, SB, SH, SE, SL, SL}, 3'd5, 1'b1, 1'b0};
    vecs[8]  = '{{SX, SH, SE, SL, SL, SO}, 3'd7, 1'b0, 1'b1};
    vecs[9]  = '{{SO, SO, SO, SO, SO, SO}, 3'd7, 1'b0, 1'b0};
    vecs[10] = '{{SB, SH, SE, SL, SL, SY}, 3'd7, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, rot, match, err}, {1'b0, 1'b0, 3'd7, 1'b0, 1'b0});
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Second start at T+3 with other digits is ignored
    @(negedge clk);
    drive_hex(vecs[0].hex);
    start = 1'b1;
    push_exp(vecs[0], cyc);
    @(negedge clk);                       // T+1
    start = 1'b0;
    @(negedge clk);                       // T+2
    @(negedge clk);                       // T+3
    drive_hex({6{SO}});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_ignored_busy", 32'(busy), 32'd1);
    wait_idle();

    // start held during DONE is taken only on the following IDLE cycle
    @(negedge clk);
    drive_hex(vecs[4].hex);
    start = 1'b1;
    push_exp(vecs[4], cyc);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 30 && !done; n++) @(negedge clk);
    chk("done_seen_for_vec4", 32'(done), 32'd1);
    drive_hex(vecs[5].hex);
    start = 1'b1;
    push_exp(vecs[5], cyc + 1);
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("start_after_done_taken", 32'(busy), 32'd1);
    wait_idle();

    // Reset at T+4 aborts without done
    @(negedge clk);
    drive_hex(vecs[0].hex);
    start = 1'b1;
    @(negedge clk);                       // T+1
    start = 1'b0;
    repeat (3) @(negedge clk);            // T+4
    begin
      int unsigned d0;
      d0 = done_seen;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_abort_state", {busy, done, rot, match, err},
          {1'b0, 1'b0, 3'd7, 1'b0, 1'b0});
      repeat (16) @(negedge clk);
      chk("reset_abort_no_done", done_seen - d0, 32'd0);
    end
    run_vec(vecs[1], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
